// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder handshake,
// next-PC control inputs and the PC/link/retirement outputs.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Jump;
  logic        JumpReg;
  logic        InvZero;
  logic        zero;
  logic [31:0] jr_target;
  logic [31:0] retired_count;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, retired_count,
    input  imem_rdata, imem_rvalid, instr_ready, Branch, Jump, JumpReg, InvZero, zero,
           jr_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4, retired_count,
    output imem_rdata, imem_rvalid, instr_ready, Branch, Jump, JumpReg, InvZero, zero,
           jr_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and single-outstanding instruction fetch: REQ -> WAIT -> HOLD,
// one instruction per retirement, next PC resolved from decoder flags at retirement.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                       clk,
  input logic                       reset_n,
  instruction_fetch_unit_if.master  ifu
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pcQ;
  logic [31:0] instrQ;
  logic        validQ;
  logic [31:0] countQ;
  logic [31:0] pcPlus4;
  logic [31:0] branchOffset;
  logic [31:0] nextPc;
  logic        branchTaken;

  assign pcPlus4      = pcQ + 32'd4;
  assign branchOffset = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};
  assign branchTaken  = ifu.Branch & (ifu.zero ^ ifu.InvZero);

  always_comb begin
    nextPc = pcPlus4;
    if (ifu.JumpReg)
      nextPc = {ifu.jr_target[31:2], 2'b00};
    else if (ifu.Jump)
      nextPc = {pcPlus4[31:28], instrQ[25:0], 2'b00};
    else if (branchTaken)
      nextPc = pcPlus4 + branchOffset;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= REQ;
      pcQ    <= RESET_PC;
      instrQ <= '0;
      validQ <= 1'b0;
      countQ <= '0;
    end else begin
      case (state)
        REQ: state <= WAIT;
        WAIT: begin
          if (ifu.imem_rvalid) begin
            instrQ <= ifu.imem_rdata;
            validQ <= 1'b1;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (ifu.instr_ready) begin
            pcQ    <= nextPc;
            validQ <= 1'b0;
            countQ <= countQ + 32'd1;
            state  <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  // Reset parks the FSM in REQ; gating with reset_n keeps the strobe low while held.
  assign ifu.imem_req      = (state == REQ) && reset_n;
  assign ifu.imem_addr     = pcQ;
  assign ifu.instruction   = instrQ;
  assign ifu.instr_valid   = validQ;
  assign ifu.pc            = pcQ;
  assign ifu.pc_plus4      = pcPlus4;
  assign ifu.retired_count = countQ;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver queues expected fetches and
// retirements, a negedge monitor pops and compares whenever the DUT presents them.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] count;
    int          cyc;
  } fetchRec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
  } retRec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int          lat;
    int          rdy;
    logic        br;
    logic        jp;
    logic        jr;
    logic        inv;
    logic        z;
    logic [31:0] jrt;
    logic [31:0] next;
  } vec_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;
  bit   timeoutHit;
  bit   timeoutSeen;
  logic [31:0] expCount;
  int   c0;

  fetchRec_t fetchQ[$];
  retRec_t   retQ[$];
  vec_t      vecs[22];

  instruction_fetch_unit_if ifu();

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ifu     (ifu.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: reset values while reset_n is low, fetch records on imem_req,
  // held/retired instruction records while instr_valid is high.
  always @(negedge clk or negedge reset_n) begin
    fetchRec_t f;
    retRec_t   r;
    if (!reset_n) begin
      #1;
      chk("rstPc", ifu.pc, RESET_PC);
      chk("rstAddr", ifu.imem_addr, RESET_PC);
      chk("rstValid", 32'(ifu.instr_valid), 32'd0);
      chk("rstReq", 32'(ifu.imem_req), 32'd0);
      chk("rstInstr", ifu.instruction, 32'd0);
      chk("rstCount", ifu.retired_count, 32'd0);
    end else begin
      if (timeoutHit && !timeoutSeen) begin
        timeoutSeen = 1'b1;
        total++;
        bad++;
        $display("FAIL reqTimeout: imem_req got 0 want 1 within bound (t=%0t)", $time);
      end
      if (ifu.imem_req) begin
        if (fetchQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpectedReq: got req at addr %h want none", ifu.imem_addr);
        end else begin
          f = fetchQ.pop_front();
          chk("fetchAddr", ifu.imem_addr, f.addr);
          chk("fetchPc", ifu.pc, f.addr);
          chk("pcPlus4", ifu.pc_plus4, f.addr + 32'd4);
          chk("reqValid", 32'(ifu.instr_valid), 32'd0);
          chk("reqCount", ifu.retired_count, f.count);
          if (f.cyc >= 0) chk("reqCycle", 32'(cyc), 32'(f.cyc));
        end
      end
      if (ifu.instr_valid) begin
        if (retQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpectedValid: got instr %h want none", ifu.instruction);
        end else begin
          chk("holdInstr", ifu.instruction, retQ[0].instr);
          chk("holdPc", ifu.pc, retQ[0].pc);
          chk("holdNoReq", 32'(ifu.imem_req), 32'd0);
          if (ifu.instr_ready) begin
            r = retQ.pop_front();
            chk("retireCount", ifu.retired_count, r.count);
          end
        end
      end
    end
  end

  task automatic waitReq(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifu.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = ifu.imem_req;
    if (!ok) timeoutHit = 1'b1;
  endtask

  task automatic clearCtl();
    ifu.Branch    = 1'b0;
    ifu.Jump      = 1'b0;
    ifu.JumpReg   = 1'b0;
    ifu.InvZero   = 1'b0;
    ifu.zero      = 1'b0;
    ifu.jr_target = 32'h0;
  endtask

  task automatic runVec(input vec_t v, input int nextCyc);
    bit ok;
    waitReq(ok);
    if (!ok) return;
    @(posedge clk); #1;
    ifu.imem_rvalid = 1'b0;
    repeat (v.lat - 1) begin
      @(posedge clk); #1;
    end
    ifu.imem_rdata  = v.word;
    ifu.imem_rvalid = 1'b1;
    retQ.push_back('{v.pc, v.word, expCount});
    @(posedge clk); #1;
    ifu.imem_rvalid = 1'b0;
    ifu.imem_rdata  = 32'hFFFF_FFFF;
    repeat (v.rdy) begin
      @(posedge clk); #1;
    end
    ifu.Branch    = v.br;
    ifu.Jump      = v.jp;
    ifu.JumpReg   = v.jr;
    ifu.InvZero   = v.inv;
    ifu.zero      = v.z;
    ifu.jr_target = v.jrt;
    fetchQ.push_back('{v.next, expCount + 32'd1, nextCyc});
    ifu.instr_ready = 1'b1;
    @(posedge clk); #1;
    ifu.instr_ready = 1'b0;
    clearCtl();
    expCount = expCount + 32'd1;
  endtask

  // Reset lands in the middle of a long WAIT; a stale rvalid is left high into the REQ after release.
  task automatic abortFetch();
    bit ok;
    waitReq(ok);
    if (!ok) return;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_n         = 1'b0;
    ifu.imem_rvalid = 1'b1;
    ifu.imem_rdata  = 32'hDEAD_BEEF;
    expCount        = 32'd0;
    fetchQ.push_back('{RESET_PC, 32'd0, -1});
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    timeoutHit = 1'b0;
    timeoutSeen = 1'b0;
    expCount = 32'd0;
    reset_n = 1'b0;
    ifu.imem_rdata  = 32'h0;
    ifu.imem_rvalid = 1'b0;
    ifu.instr_ready = 1'b0;
    clearCtl();

    //          pc            word          lat rdy br jp jr inv z  jr_target     next
    vecs[0]  = '{32'h0000_0000, 32'h0000_0001, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0004};
    vecs[1]  = '{32'h0000_0004, 32'h0000_0002, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0008};
    vecs[2]  = '{32'h0000_0008, 32'h0000_0003, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_000C};
    vecs[3]  = '{32'h0000_000C, 32'h0000_0004, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0010};
    vecs[4]  = '{32'h0000_0010, 32'h0000_0005, 1, 5, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0014};
    vecs[5]  = '{32'h0000_0014, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'h0000_0100, 32'h0000_0100};
    vecs[6]  = '{32'h0000_0100, 32'h1000_FFFE, 1, 0, 1, 0, 0, 0, 1, 32'h0,        32'h0000_00FC};
    vecs[7]  = '{32'h0000_00FC, 32'h0000_0006, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0100};
    vecs[8]  = '{32'h0000_0100, 32'h1400_FFFE, 1, 0, 1, 0, 0, 1, 1, 32'h0,        32'h0000_0104};
    vecs[9]  = '{32'h0000_0104, 32'h1400_0003, 1, 0, 1, 0, 0, 1, 0, 32'h0,        32'h0000_0114};
    vecs[10] = '{32'h0000_0114, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'h1000_0010, 32'h1000_0010};
    vecs[11] = '{32'h1000_0010, 32'h0800_0040, 1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h1000_0100};
    vecs[12] = '{32'h1000_0100, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'h1000_0013, 32'h1000_0010};
    vecs[13] = '{32'h1000_0010, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'h0000_2003, 32'h0000_2000};
    vecs[14] = '{32'h0000_2000, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'h1000_0010, 32'h1000_0010};
    vecs[15] = '{32'h1000_0010, 32'h0800_0040, 1, 0, 0, 1, 1, 0, 0, 32'h0000_2003, 32'h0000_2000};
    vecs[16] = '{32'h0000_2000, 32'h0800_0800, 1, 0, 1, 1, 0, 0, 1, 32'h0,        32'h0000_2000};
    vecs[17] = '{32'h0000_2000, 32'h0000_0007, 4, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_2004};
    vecs[18] = '{32'h0000_2004, 32'h03E0_0008, 1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[19] = '{32'hFFFF_FFFC, 32'h0000_0008, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0000};
    vecs[20] = '{32'h0000_0000, 32'h0000_0009, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0004};
    vecs[21] = '{32'h0000_0000, 32'h0000_000A, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0000_0004};

    repeat (3) @(posedge clk);
    #1;
    c0 = cyc;
    fetchQ.push_back('{RESET_PC, 32'd0, c0});
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      if (!timeoutHit) runVec(vecs[i], (i < 4) ? c0 + 3 * (i + 1) : -1);
    end
    if (!timeoutHit) abortFetch();
    if (!timeoutHit) runVec(vecs[21], -1);

    repeat (3) @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
